nios_pio_arbiter: RTL

Two-requester round-robin arbiter and bus sequencer for a single Avalon-MM PIO slave register block in the ReCOP/NIOS subsystem. It serialises read and write requests from two masters (requester 0: NIOS-side glue, requester 1: ReCOP-side glue) onto one PIO slave port. It drives `chipselect`, `write_n`, `address` and `writedata` for exactly one cycle per transaction and returns read data with a one-cycle acknowledge pulse.

---
 rtl/nios_pio_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/nios_pio_arbiter.sv
// rtl/nios_pio_arbiter.sv - two-requester round-robin arbiter sequencing one Avalon-MM PIO slave
module nios_pio_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            req,
   input  logic [1:0]            req_wr,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            ack,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic [ADDR_W-1:0]     pio_address,
   output logic                  pio_chipselect,
   output logic                  pio_write_n,
   output logic [DATA_W-1:0]     pio_writedata,
   input  logic [DATA_W-1:0]     pio_readdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                winner_q, winner_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                cs_q, cs_d;
   logic                write_n_q, write_n_d;
   logic [1:0]          ack_q, ack_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                grant;

   // Alternate on contention; a lone requester always wins.
   always_comb begin
      if (req == 2'b11) begin
         grant = ~last_q;
      end else begin
         grant = req[1];
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      winner_d  = winner_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      cs_d      = 1'b0;
      write_n_d = 1'b1;
      ack_d     = 2'b00;

      case (state_q)
         IDLE: begin
            if (|req) begin
               winner_d  = grant;
               last_d    = grant;
               wr_d      = req_wr[grant];
               addr_d    = grant ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
               wdata_d   = grant ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
               cs_d      = 1'b1;
               write_n_d = ~req_wr[grant];
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            // Slave is zero-wait-state, so readdata is valid during the strobe cycle.
            if (!wr_q) begin
               rdata_d = pio_readdata;
            end
            ack_d   = winner_q ? 2'b10 : 2'b01;
            state_d = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         winner_q  <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         cs_q      <= 1'b0;
         write_n_q <= 1'b1;
         ack_q     <= 2'b00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         winner_q  <= winner_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         cs_q      <= cs_d;
         write_n_q <= write_n_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   assign ack            = ack_q;
   assign rdata          = rdata_q;
   assign busy           = busy_q;
   assign pio_address    = addr_q;
   assign pio_chipselect = cs_q;
   assign pio_write_n    = write_n_q;
   assign pio_writedata  = wdata_q;

endmodule
